// File: rtl/hwpe_stream_tcdm_loader.sv
// Strided TCDM read engine feeding a valid/ready stream; first word is valid 3 cycles after start.
// Sink backpressure parks words in the response FIFO; requests pause once FIFO plus in-flight reach capacity.

module hwpe_stream_tcdm_loader_fifo #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [DW-1:0]              data_i,
  input  logic                       pop_i,
  output logic [DW-1:0]              data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     occ_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_L = (PW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   occ_q, occ_d;
  logic          full;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    if (push_i) begin
      mem_d[wr_q] = data_i;
      wr_d        = wr_q + PW'(1);
    end
    if (pop_i) begin
      rd_d = rd_q + PW'(1);
    end
    if (push_i && !pop_i) begin
      occ_d = occ_q + (PW+1)'(1);
    end else if (pop_i && !push_i) begin
      occ_d = occ_q - (PW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

  // Storage needs no reset: the head is only visible while the FIFO is non-empty.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign full    = (occ_q == FULL_L);
  assign empty_o = (occ_q == '0);
  assign occ_o   = occ_q;
  assign data_o  = mem_q[rd_q];

  a_no_overflow: assert property (@(posedge clk_i) disable iff (clear_i) !(push_i && full));

endmodule

module hwpe_stream_tcdm_loader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [ADDR_WIDTH-1:0]   stride_i,
  input  logic [CNT_WIDTH-1:0]    count_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    tcdm_req_o,
  input  logic                    tcdm_gnt_i,
  output logic [ADDR_WIDTH-1:0]   tcdm_add_o,
  output logic                    tcdm_wen_o,
  output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
  output logic [DATA_WIDTH-1:0]   tcdm_data_o,
  input  logic [DATA_WIDTH-1:0]   tcdm_r_data_i,
  input  logic                    tcdm_r_valid_i,
  output logic                    stream_valid_o,
  input  logic                    stream_ready_i,
  output logic [DATA_WIDTH-1:0]   stream_data_o,
  output logic [DATA_WIDTH/8-1:0] stream_strb_o
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW+1:0]      CREDIT_MAX = (PW+2)'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, stride_q, stride_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d, issue_q, issue_d, out_q, out_d;
  logic                  inflight_q, inflight_d;
  logic                  busy_q, busy_d, done_q, done_d;

  logic [PW:0]           fifo_occ;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic [PW+1:0]         credit_used;
  logic                  req, gnt_fire, push, pop;

  always_comb begin
    credit_used = {1'b0, fifo_occ} + {{(PW+1){1'b0}}, inflight_q};
    req         = (state_q == REQ) && (credit_used < CREDIT_MAX);
    gnt_fire    = req && tcdm_gnt_i;
    push        = tcdm_r_valid_i && inflight_q;
    pop         = !fifo_empty && stream_ready_i;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    stride_d   = stride_q;
    count_d    = count_q;
    issue_d    = issue_q;
    out_d      = pop ? out_q + CNT_ONE : out_q;
    inflight_d = gnt_fire || (inflight_q && !tcdm_r_valid_i);
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d   = base_addr_i;
          stride_d = stride_i;
          count_d  = count_i;
          issue_d  = '0;
          out_d    = '0;
          // An empty job passes through DRAIN so done lands two cycles after start.
          state_d  = (count_i != '0) ? REQ : DRAIN;
        end
      end
      REQ: begin
        if (gnt_fire) begin
          issue_d = issue_q + CNT_ONE;
          if (issue_q + CNT_ONE == count_q) begin
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + stride_q;
          end
        end
      end
      DRAIN: begin
        if ((count_q == '0) || (pop && (out_q + CNT_ONE == count_q))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      count_q    <= '0;
      issue_q    <= '0;
      out_q      <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      count_q    <= count_d;
      issue_q    <= issue_d;
      out_q      <= out_d;
      inflight_q <= inflight_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  hwpe_stream_tcdm_loader_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) i_fifo (
    .clk_i   (clk_i),
    .clear_i (clear_i),
    .push_i  (push),
    .data_i  (tcdm_r_data_i),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .empty_o (fifo_empty),
    .occ_o   (fifo_occ)
  );

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign tcdm_req_o     = req;
  assign tcdm_add_o     = addr_q;
  assign tcdm_wen_o     = 1'b1;
  assign tcdm_be_o      = '1;
  assign tcdm_data_o    = '0;
  assign stream_valid_o = !fifo_empty;
  assign stream_data_o  = fifo_empty ? '0 : fifo_data;
  assign stream_strb_o  = fifo_empty ? '0 : '1;

endmodule

// File: tb/tb_hwpe_stream_tcdm_loader.sv
// Bench for hwpe_stream_tcdm_loader: directed jobs, TCDM responder model, queue-based scoreboard.
module tb_hwpe_stream_tcdm_loader;
  localparam logic [31:0] DKEY = 32'hDEAD_0000;

  logic        clk_i = 1'b0;
  logic        clear_i, start_i;
  logic [31:0] base_addr_i, stride_i;
  logic [15:0] count_i;
  logic        busy_o, done_o, tcdm_req_o, tcdm_gnt_i, tcdm_wen_o;
  logic [31:0] tcdm_add_o, tcdm_data_o, tcdm_r_data_i, stream_data_o;
  logic [3:0]  tcdm_be_o, stream_strb_o;
  logic        tcdm_r_valid_i, stream_valid_o, stream_ready_i;

  hwpe_stream_tcdm_loader #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(16), .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk_i), .clear_i(clear_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .stride_i(stride_i), .count_i(count_i),
    .busy_o(busy_o), .done_o(done_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
    .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
    .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i),
    .stream_valid_o(stream_valid_o), .stream_ready_i(stream_ready_i),
    .stream_data_o(stream_data_o), .stream_strb_o(stream_strb_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int          cyc = 0, c0 = 0;
  int          n_checks = 0, n_fail = 0;
  int          grants, valid_cycles, done_n, done_rel, first_req, first_valid, stall_cycles;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] a);
    exp_addr.push_back(a);
    exp_data.push_back(a ^ DKEY);
  endtask

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // TCDM slave: answers every handshake exactly one cycle later with addr ^ DKEY.
  initial begin
    logic        hs;
    logic [31:0] ha;
    tcdm_r_valid_i = 1'b0;
    tcdm_r_data_i  = '0;
    forever begin
      @(negedge clk_i);
      hs = tcdm_req_o && tcdm_gnt_i;
      ha = tcdm_add_o;
      @(posedge clk_i);
      #1;
      tcdm_r_valid_i = hs;
      tcdm_r_data_i  = hs ? (ha ^ DKEY) : 32'h0;
    end
  end

  // Monitor: scoreboard pops, request-hold and stream-hold rules, per-job statistics.
  initial begin
    logic        stall_prev = 1'b0, hold_prev = 1'b0;
    logic [31:0] stall_add = '0, hold_dat = '0;
    int          rel;
    forever begin
      @(negedge clk_i);
      rel = cyc - c0;
      if (tcdm_req_o && first_req < 0) first_req = rel;
      if (stream_valid_o && first_valid < 0) first_valid = rel;
      if (stream_valid_o) valid_cycles++;
      if (done_o) begin
        done_n++;
        done_rel = rel;
      end
      if (stall_prev) begin
        check("stall_req_held", {31'b0, tcdm_req_o}, 32'd1);
        check("stall_add_stable", tcdm_add_o, stall_add);
      end
      if (hold_prev) begin
        check("hold_valid", {31'b0, stream_valid_o}, 32'd1);
        check("hold_data", stream_data_o, hold_dat);
      end
      if (tcdm_req_o && tcdm_gnt_i) begin
        grants++;
        if (exp_addr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_grant: got address 0x%08h, expected no request", tcdm_add_o);
        end else begin
          check("tcdm_addr", tcdm_add_o, exp_addr.pop_front());
        end
      end
      if (stream_valid_o && stream_ready_i) begin
        check("stream_strb", {28'b0, stream_strb_o}, 32'hF);
        if (exp_data.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%08h, expected no stream word", stream_data_o);
        end else begin
          check("stream_data", stream_data_o, exp_data.pop_front());
        end
      end
      if (tcdm_req_o && !tcdm_gnt_i) stall_cycles++;
      stall_prev = tcdm_req_o && !tcdm_gnt_i;
      stall_add  = tcdm_add_o;
      hold_prev  = stream_valid_o && !stream_ready_i;
      hold_dat   = stream_data_o;
    end
  end

  task automatic go_cycle(input int k);
    while ((cyc - c0) < k) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic sample_at(input int k);
    go_cycle(k);
    @(negedge clk_i);
  endtask

  task automatic start_xfer(input logic [31:0] base, input logic [31:0] stride, input logic [15:0] cnt);
    @(posedge clk_i);
    #1;
    start_i      = 1'b1;
    base_addr_i  = base;
    stride_i     = stride;
    count_i      = cnt;
    c0           = cyc;
    grants       = 0;
    valid_cycles = 0;
    done_n       = 0;
    done_rel     = -1;
    first_req    = -1;
    first_valid  = -1;
    stall_cycles = 0;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_i = 1'b1; start_i = 1'b0; base_addr_i = '0; stride_i = '0; count_i = '0;
    tcdm_gnt_i = 1'b1; stream_ready_i = 1'b1;
    grants = 0; valid_cycles = 0; done_n = 0; done_rel = -1; first_req = -1; first_valid = -1;
    stall_cycles = 0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    check("rst_req", {31'b0, tcdm_req_o}, 32'd0);
    check("rst_add", tcdm_add_o, 32'd0);
    check("rst_valid", {31'b0, stream_valid_o}, 32'd0);
    check("rst_data", stream_data_o, 32'd0);
    check("rst_strb", {28'b0, stream_strb_o}, 32'd0);
    check("const_wen", {31'b0, tcdm_wen_o}, 32'd1);
    check("const_be", {28'b0, tcdm_be_o}, 32'hF);
    check("const_wdata", tcdm_data_o, 32'd0);
    @(posedge clk_i);
    #1;
    clear_i = 1'b0;

    // Basic job
    for (int i = 0; i < 4; i++) expect_word(32'h100 + 32'(4 * i));
    start_xfer(32'h100, 32'd4, 16'd4);
    go_cycle(12);
    check("basic_first_req", first_req, 32'd1);
    check("basic_first_valid", first_valid, 32'd3);
    check("basic_done_cycle", done_rel, 32'd7);
    check("basic_done_count", done_n, 32'd1);
    check("basic_grants", grants, 32'd4);
    check("basic_valid_cycles", valid_cycles, 32'd4);

    // Grant stall on the second request
    for (int i = 0; i < 4; i++) expect_word(32'h100 + 32'(4 * i));
    start_xfer(32'h100, 32'd4, 16'd4);
    go_cycle(2);
    tcdm_gnt_i = 1'b0;
    go_cycle(5);
    tcdm_gnt_i = 1'b1;
    go_cycle(16);
    check("stall_cycles", stall_cycles, 32'd3);
    check("stall_done_cycle", done_rel, 32'd10);
    check("stall_done_count", done_n, 32'd1);

    // Sink backpressure
    stream_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) expect_word(32'h200 + 32'(16 * i));
    start_xfer(32'h200, 32'h10, 16'd8);
    sample_at(11);
    check("bp_grants_capped", grants, 32'd4);
    check("bp_req_dropped", {31'b0, tcdm_req_o}, 32'd0);
    check("bp_valid_held", {31'b0, stream_valid_o}, 32'd1);
    check("bp_head_data", stream_data_o, 32'h200 ^ DKEY);
    go_cycle(12);
    stream_ready_i = 1'b1;
    go_cycle(30);
    check("bp_grants_total", grants, 32'd8);
    check("bp_done_count", done_n, 32'd1);

    // Address wrap
    expect_word(32'hFFFF_FFF8);
    expect_word(32'hFFFF_FFFC);
    expect_word(32'h0000_0000);
    expect_word(32'h0000_0004);
    start_xfer(32'hFFFF_FFF8, 32'd4, 16'd4);
    go_cycle(12);
    check("wrap_done_count", done_n, 32'd1);
    check("wrap_grants", grants, 32'd4);

    // Zero-length job
    start_xfer(32'h700, 32'd4, 16'd0);
    go_cycle(6);
    check("zero_done_cycle", done_rel, 32'd2);
    check("zero_done_count", done_n, 32'd1);
    check("zero_grants", grants, 32'd0);
    check("zero_valid_cycles", valid_cycles, 32'd0);

    // start_i while busy and in the DONE cycle is ignored
    for (int i = 0; i < 3; i++) expect_word(32'h300 + 32'(4 * i));
    start_xfer(32'h300, 32'd4, 16'd3);
    go_cycle(2);
    start_i = 1'b1; base_addr_i = 32'h900; stride_i = 32'h40; count_i = 16'd2;
    go_cycle(3);
    start_i = 1'b0;
    go_cycle(6);
    start_i = 1'b1;
    go_cycle(7);
    start_i = 1'b0;
    sample_at(8);
    check("busy_ign_done_cycle", done_rel, 32'd6);
    check("busy_ign_grants", grants, 32'd3);
    check("busy_ign_idle_busy", {31'b0, busy_o}, 32'd0);
    check("busy_ign_idle_req", {31'b0, tcdm_req_o}, 32'd0);

    // clear_i mid-transfer after two grants, then a fresh job
    stream_ready_i = 1'b0;
    expect_word(32'h400);
    expect_word(32'h404);
    exp_data.delete();
    start_xfer(32'h400, 32'd4, 16'd8);
    go_cycle(2);
    clear_i = 1'b1;
    go_cycle(3);
    clear_i = 1'b0;
    @(negedge clk_i);
    check("clr_req", {31'b0, tcdm_req_o}, 32'd0);
    check("clr_valid", {31'b0, stream_valid_o}, 32'd0);
    check("clr_busy", {31'b0, busy_o}, 32'd0);
    sample_at(5);
    check("clr_late_rvalid_ignored", {31'b0, stream_valid_o}, 32'd0);
    check("clr_grants", grants, 32'd2);
    stream_ready_i = 1'b1;
    expect_word(32'h500);
    expect_word(32'h508);
    start_xfer(32'h500, 32'd8, 16'd2);
    go_cycle(10);
    check("post_clr_done_count", done_n, 32'd1);
    check("post_clr_done_cycle", done_rel, 32'd5);

    check("sb_addr_left", exp_addr.size(), 32'd0);
    check("sb_data_left", exp_data.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
